// File: rtl/orv64_fetch_buf.sv
// First-word-fall-through instruction buffer between IF and ID, flushed by kill.
// Optional macro ORV64_FETCH_BUF_BYPASS_EN adds a 0-cycle empty-buffer bypass.
module orv64_fetch_buf #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 39,
   parameter int INST_W = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic              in_excp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic              out_excp,
   input  logic              kill,
   output logic [CNT_W-1:0]  count
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [PC_W-1:0]   pcMem_q   [DEPTH];
   logic [INST_W-1:0] instMem_q [DEPTH];
   logic              excpMem_q [DEPTH];

   logic [CNT_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] wrPtr_q, wrPtr_d;
   logic [IDX_W-1:0] rdIdx, wrIdx;
   logic             empty, full, push, pop, wrEn;

   assign rdIdx = rdPtr_q[IDX_W-1:0];
   assign wrIdx = wrPtr_q[IDX_W-1:0];
   assign empty = (rdPtr_q == wrPtr_q);
   assign full  = (rdIdx == wrIdx) && (rdPtr_q[CNT_W-1] != wrPtr_q[CNT_W-1]);
   assign count = wrPtr_q - rdPtr_q;

   assign in_ready = ~full & ~kill;
   assign push     = in_valid & in_ready;

`ifdef ORV64_FETCH_BUF_BYPASS_EN
   logic bypassAvail;

   // An empty buffer forwards the incoming entry; it is stored only if ID stalls.
   assign bypassAvail = empty & in_valid & ~kill;
   assign out_valid   = (~empty & ~kill) | bypassAvail;
   assign out_pc      = empty ? in_pc   : pcMem_q[rdIdx];
   assign out_inst    = empty ? in_inst : instMem_q[rdIdx];
   assign out_excp    = empty ? in_excp : excpMem_q[rdIdx];
   assign pop         = ~empty & ~kill & out_ready;
   assign wrEn        = push & ~(bypassAvail & out_ready);
`else
   assign out_valid = ~empty & ~kill;
   assign out_pc    = pcMem_q[rdIdx];
   assign out_inst  = instMem_q[rdIdx];
   assign out_excp  = excpMem_q[rdIdx];
   assign pop       = out_valid & out_ready;
   assign wrEn      = push;
`endif

   // kill discards everything buffered by snapping the read pointer to the write pointer.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      if (kill) begin
         rdPtr_d = wrPtr_q;
      end else begin
         if (wrEn) wrPtr_d = wrPtr_q + CNT_W'(1);
         if (pop)  rdPtr_d = rdPtr_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) begin
         pcMem_q[wrIdx]   <= in_pc;
         instMem_q[wrIdx] <= in_inst;
         excpMem_q[wrIdx] <= in_excp;
      end
   end

endmodule

// File: tb/tb_orv64_fetch_buf.sv
// Scoreboard bench for orv64_fetch_buf: directed scenarios followed by randomized traffic.
module tb_orv64_fetch_buf;

   localparam int DEPTH  = 4;
   localparam int PC_W   = 39;
   localparam int INST_W = 32;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef logic [PC_W+INST_W:0] entry_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [INST_W-1:0] in_inst;
   logic              in_excp;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              out_excp;
   logic              kill;
   logic [CNT_W-1:0]  count;

   int checks = 0;
   int fails  = 0;

   entry_t expQ[$];
   logic   expInReady;
   logic   bypassTaken;

   orv64_fetch_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst), .in_excp(in_excp),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_excp(out_excp),
      .kill(kill), .count(count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output side: the buffer's contents are modelled as an ordered queue of accepted entries.
   always @(negedge clk) begin
      entry_t head;
      logic   expOutValid;
      #2;
      bypassTaken = 1'b0;
      if (!rst) begin
         expInReady  = (expQ.size() < DEPTH) && !kill;
         expOutValid = !kill && (expQ.size() > 0);
`ifdef ORV64_FETCH_BUF_BYPASS_EN
         expOutValid = expOutValid || (!kill && expQ.size() == 0 && in_valid);
`endif
         checkOutput("count", 64'(count), 64'(expQ.size()));
         checkOutput("in_ready", 64'(in_ready), 64'(expInReady));
         checkOutput("out_valid", 64'(out_valid), 64'(expOutValid));
         checkOutput("no_push_when_full", 64'(in_valid && in_ready && count == CNT_W'(DEPTH)), 64'd0);
`ifndef ORV64_FETCH_BUF_BYPASS_EN
         checkOutput("no_pop_when_empty", 64'(out_valid && out_ready && count == '0), 64'd0);
`endif
         checkOutput("count_le_depth", 64'(count <= CNT_W'(DEPTH)), 64'd1);
         if (out_valid && expOutValid) begin
            head = (expQ.size() > 0) ? expQ[0] : {in_pc, in_inst, in_excp};
            checkOutput("out_pc", 64'(out_pc), 64'(head[PC_W+INST_W:INST_W+1]));
            checkOutput("out_inst", 64'(out_inst), 64'(head[INST_W:1]));
            checkOutput("out_excp", 64'(out_excp), 64'(head[0]));
            if (out_ready) begin
               if (expQ.size() > 0) void'(expQ.pop_front());
               else bypassTaken = 1'b1;
            end
         end
      end
   end

   // Input side: accepted stimulus becomes an expected future output.
   always @(negedge clk) begin
      #3;
      if (rst || kill) begin
         expQ.delete();
      end else if (in_valid && expInReady && !bypassTaken) begin
         expQ.push_back({in_pc, in_inst, in_excp});
      end
   end

   task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                                input logic excp, input logic ordy, input logic k);
      @(negedge clk);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst;
      in_excp   = excp;
      out_ready = ordy;
      kill      = k;
   endtask

   initial begin
      logic [PC_W-1:0] pc;
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_excp = 1'b0; out_ready = 1'b0; kill = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Fill to full, then offer a fifth entry that must be refused.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, PC_W'(39'h1000 + 4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Streaming across pointer wrap.
      pc = 39'h5000;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, pc, $urandom, 1'b0, 1'b1, 1'b0);
         pc = pc + 4;
      end
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Kill with three buffered entries and a concurrent push.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, PC_W'(39'h6000 + 4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 39'h2000, $urandom, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 39'h3000, 32'h13, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Exception flag carried by one entry only.
      applyStimulus(1'b1, 39'h4000, 32'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 39'h4004, 32'h33, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic with occasional kill and reset.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, PC_W'({$urandom, $urandom}), $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, (i / 150) + 1) != 0,
                       $urandom_range(0, 24) == 0);
         rst = ($urandom_range(0, 99) == 0);
      end
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
